// File: rtl/ag32gbd_ram_read.sv
// Reads one 256-byte SRAM tile block and unpacks the 2bpp bit-plane pairs into linear packed pixels.
// Optional macro RAM_READ_CHECKSUM_EN adds an 8-bit wrapping sum of all captured SRAM bytes.
module ag32gbd_ram_read #(
  parameter int CE_SETUP_CYCLES  = 10,
  parameter int READ_WAIT_CYCLES = 6
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        NewRunReset,
  input  logic        BlockReadRequest,
  output logic        Gbd_Reading_Ram,
  output logic [11:0] Ram_Reading_Addr_Low,
  input  logic [7:0]  Ram_Reading_Data,
  output logic        Ram_Reading_nCS,
  output logic        Ram_Reading_nOE,
  output logic        RequestWriteBuffer,
  output logic [9:0]  WriteBufferOffset,
  output logic [7:0]  WriteBufferData,
  input  logic        BufferWriteAck,
  output logic        BlockReadDone,
  output logic [7:0]  BlockChecksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_LO, S_RD_HI, S_WR_B, S_WR_A, S_NEXT, S_FINISH
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CE_SETUP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(READ_WAIT_CYCLES - 1);

  logic       req_meta_q, req_sync_q, req_prev_q, edge_q;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] n_q, n_d;
  logic [3:0] round_q, round_d;
  logic [7:0] lo_q, lo_d, hi_q, hi_d;
  logic [11:0] addr_q, addr_d;
  logic       ncs_q, ncs_d, noe_q, noe_d;
  logic       wreq_q, wreq_d;
  logic [7:0] woff_q, woff_d, wdat_q, wdat_d;
  logic       done_q, done_d;
  logic [7:0] pix_a, pix_b;
  logic [6:0] n_inc;
  logic       clear;

  assign clear = sys_reset | NewRunReset;
  assign n_inc = n_q + 7'd1;

  // Each output pixel pair is {H bit, L bit}; A holds the upper nibbles, B the lower.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign pix_a[2*gi+1] = hi_q[4+gi];
      assign pix_a[2*gi]   = lo_q[4+gi];
      assign pix_b[2*gi+1] = hi_q[gi];
      assign pix_b[2*gi]   = lo_q[gi];
    end
  endgenerate

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
      req_prev_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      req_meta_q <= BlockReadRequest;
      req_sync_q <= req_meta_q;
      req_prev_q <= req_sync_q;
      edge_q     <= req_sync_q & ~req_prev_q;
    end
  end

`ifdef RAM_READ_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign BlockChecksum = csum_q;
`else
  assign BlockChecksum = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    round_d = round_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    ncs_d   = ncs_q;
    noe_d   = noe_q;
    wreq_d  = wreq_q;
    woff_d  = woff_q;
    wdat_d  = wdat_q;
    done_d  = 1'b0;
`ifdef RAM_READ_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (edge_q) begin
          ncs_d   = 1'b0;
          cnt_d   = 8'd0;
          n_d     = 7'd0;
          state_d = S_SETUP;
`ifdef RAM_READ_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          addr_d  = {round_q, n_q, 1'b0};
          noe_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_RD_LO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD_LO: begin
        // The high-byte address is applied on the capture edge, a full wait ahead of its own capture.
        if (cnt_q == WAIT_LAST) begin
          lo_d    = Ram_Reading_Data;
          addr_d  = {round_q, n_q, 1'b1};
          cnt_d   = 8'd0;
          state_d = S_RD_HI;
`ifdef RAM_READ_CHECKSUM_EN
          csum_d  = csum_q + Ram_Reading_Data;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD_HI: begin
        if (cnt_q == WAIT_LAST) begin
          hi_d    = Ram_Reading_Data;
          noe_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_WR_B;
`ifdef RAM_READ_CHECKSUM_EN
          csum_d  = csum_q + Ram_Reading_Data;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WR_B: begin
        if (wreq_q) begin
          if (BufferWriteAck) begin
            wreq_d  = 1'b0;
            state_d = S_WR_A;
          end
        end else if (!BufferWriteAck) begin
          wreq_d = 1'b1;
          woff_d = {n_q[2:0], n_q[6:3], 1'b0};
          wdat_d = pix_b;
        end
      end
      S_WR_A: begin
        if (wreq_q) begin
          if (BufferWriteAck) begin
            wreq_d  = 1'b0;
            state_d = S_NEXT;
          end
        end else if (!BufferWriteAck) begin
          wreq_d = 1'b1;
          woff_d = {n_q[2:0], n_q[6:3], 1'b1};
          wdat_d = pix_a;
        end
      end
      S_NEXT: begin
        if (n_q == 7'd127) begin
          state_d = S_FINISH;
        end else begin
          n_d     = n_inc;
          addr_d  = {round_q, n_inc, 1'b0};
          noe_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_RD_LO;
        end
      end
      S_FINISH: begin
        ncs_d   = 1'b1;
        noe_d   = 1'b1;
        addr_d  = 12'h000;
        round_d = round_q + 4'd1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      n_q     <= 7'd0;
      round_q <= 4'd0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      addr_q  <= 12'h000;
      ncs_q   <= 1'b1;
      noe_q   <= 1'b1;
      wreq_q  <= 1'b0;
      woff_q  <= 8'h00;
      wdat_q  <= 8'h00;
      done_q  <= 1'b0;
`ifdef RAM_READ_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      round_q <= round_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      ncs_q   <= ncs_d;
      noe_q   <= noe_d;
      wreq_q  <= wreq_d;
      woff_q  <= woff_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
`ifdef RAM_READ_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign Gbd_Reading_Ram      = (state_q != S_IDLE);
  assign Ram_Reading_Addr_Low = addr_q;
  assign Ram_Reading_nCS      = ncs_q;
  assign Ram_Reading_nOE      = noe_q;
  assign RequestWriteBuffer   = wreq_q;
  assign WriteBufferOffset    = {2'b00, woff_q};
  assign WriteBufferData      = wdat_q;
  assign BlockReadDone        = done_q;

endmodule

// File: tb/tb_ag32gbd_ram_read.sv
// Directed and loopback bench for ag32gbd_ram_read: SRAM model, acking buffer model, tile-writer reference.
module tb_ag32gbd_ram_read;

  logic        sys_clock = 1'b0;
  logic        sys_reset, NewRunReset, BlockReadRequest, BufferWriteAck;
  logic        Gbd_Reading_Ram, Ram_Reading_nCS, Ram_Reading_nOE;
  logic        RequestWriteBuffer, BlockReadDone;
  logic [11:0] Ram_Reading_Addr_Low;
  logic [7:0]  Ram_Reading_Data, WriteBufferData, BlockChecksum;
  logic [9:0]  WriteBufferOffset;

  logic [7:0]  sram [4096];
  logic [7:0]  obuf [256];
  logic [7:0]  src  [16][256];
  logic [9:0]  log_off [$];
  logic [7:0]  log_dat [$];

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int ack_mode = 0;
  int wait_cnt = 0;
  logic        pending = 1'b0;
  logic [17:0] held;
  int          ncs_lat, first_addr;
  logic        got_done;

  always #5 sys_clock = ~sys_clock;

  assign Ram_Reading_Data = (Ram_Reading_nOE | Ram_Reading_nCS) ? 8'h00 : sram[Ram_Reading_Addr_Low];

  ag32gbd_ram_read dut (
    .sys_clock            (sys_clock),
    .sys_reset            (sys_reset),
    .NewRunReset          (NewRunReset),
    .BlockReadRequest     (BlockReadRequest),
    .Gbd_Reading_Ram      (Gbd_Reading_Ram),
    .Ram_Reading_Addr_Low (Ram_Reading_Addr_Low),
    .Ram_Reading_Data     (Ram_Reading_Data),
    .Ram_Reading_nCS      (Ram_Reading_nCS),
    .Ram_Reading_nOE      (Ram_Reading_nOE),
    .RequestWriteBuffer   (RequestWriteBuffer),
    .WriteBufferOffset    (WriteBufferOffset),
    .WriteBufferData      (WriteBufferData),
    .BufferWriteAck       (BufferWriteAck),
    .BlockReadDone        (BlockReadDone),
    .BlockChecksum        (BlockChecksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Buffer side: acks after 0 cycles, or a random 0/1/7 cycles when ack_mode is set.
  initial begin
    BufferWriteAck = 1'b0;
    forever begin
      @(posedge sys_clock);
      #1;
      if (BufferWriteAck) begin
        BufferWriteAck = 1'b0;
      end else if (RequestWriteBuffer) begin
        if (!pending) begin
          pending = 1'b1;
          held = {WriteBufferOffset, WriteBufferData};
          case ($urandom_range(0, 2))
            0: wait_cnt = 0;
            1: wait_cnt = 1;
            default: wait_cnt = 7;
          endcase
          if (ack_mode == 0) wait_cnt = 0;
        end
        if (wait_cnt == 0) begin
          chk("req_stable", {14'd0, WriteBufferOffset, WriteBufferData}, {14'd0, held});
          chk("off_hi_zero", {30'd0, WriteBufferOffset[9:8]}, 32'd0);
          obuf[WriteBufferOffset[7:0]] = WriteBufferData;
          log_off.push_back(WriteBufferOffset);
          log_dat.push_back(WriteBufferData);
          wr_count++;
          BufferWriteAck = 1'b1;
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  // Forward tile writer: linear packed pixels of one round into bit-plane pairs in SRAM.
  task automatic tile_write(input int rnd);
    logic [7:0] a, b, l, h;
    for (int p = 0; p < 16; p++) begin
      for (int iy = 0; iy < 8; iy++) begin
        b = src[rnd][iy*32 + 2*p];
        a = src[rnd][iy*32 + 2*p + 1];
        for (int j = 0; j < 4; j++) begin
          l[j] = b[2*j];  h[j] = b[2*j+1];
          l[4+j] = a[2*j]; h[4+j] = a[2*j+1];
        end
        sram[rnd*256 + (p*8+iy)*2]     = l;
        sram[rnd*256 + (p*8+iy)*2 + 1] = h;
      end
    end
  endtask

  function automatic logic [7:0] exp_csum(input int rnd);
    logic [7:0] s;
    s = 8'h00;
`ifdef RAM_READ_CHECKSUM_EN
    for (int i = 0; i < 256; i++) s = s + sram[rnd*256 + i];
`endif
    return s;
  endfunction

  task automatic pulse_new_run();
    NewRunReset = 1'b1;
    @(posedge sys_clock);
    #1;
    NewRunReset = 1'b0;
  endtask

  // Raises the request, waits (bounded) for BlockReadDone, records nCS latency and first address.
  task automatic run_block();
    wr_count = 0;
    log_off.delete();
    log_dat.delete();
    ncs_lat = -1;
    first_addr = -1;
    got_done = 1'b0;
    BlockReadRequest = 1'b1;
    for (int i = 1; i <= 20000; i++) begin
      @(posedge sys_clock);
      #1;
      if (ncs_lat < 0 && !Ram_Reading_nCS) ncs_lat = i;
      if (first_addr < 0 && !Ram_Reading_nOE) first_addr = int'(Ram_Reading_Addr_Low);
      if (BlockReadDone) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
    BlockReadRequest = 1'b0;
  endtask

  initial begin
    int nerr;
    logic [7:0] exp_sum;
    sys_reset = 1'b1;
    NewRunReset = 1'b0;
    BlockReadRequest = 1'b0;
    for (int i = 0; i < 4096; i++) sram[i] = 8'h00;
    for (int i = 0; i < 256; i++) obuf[i] = 8'hEE;
    repeat (3) @(posedge sys_clock);
    #1;
    sys_reset = 1'b0;
    chk("rst_ncs", {31'd0, Ram_Reading_nCS}, 32'd1);
    chk("rst_noe", {31'd0, Ram_Reading_nOE}, 32'd1);
    chk("rst_req", {31'd0, RequestWriteBuffer}, 32'd0);
    chk("rst_addr", {20'd0, Ram_Reading_Addr_Low}, 32'd0);
    chk("rst_busy", {31'd0, Gbd_Reading_Ram}, 32'd0);
    chk("rst_done", {31'd0, BlockReadDone}, 32'd0);
    chk("rst_off_dat", {14'd0, WriteBufferOffset, WriteBufferData}, 32'd0);
    chk("rst_csum", {24'd0, BlockChecksum}, 32'd0);

    // Directed block, round 0.
    sram[12'h000] = 8'hF0; sram[12'h001] = 8'h0F;
    sram[12'h002] = 8'hFF; sram[12'h003] = 8'h00;
    sram[12'h010] = 8'h3C; sram[12'h011] = 8'hA5;
    run_block();
    chk("ncs_latency", ncs_lat, 4);
    chk("dir_writes", wr_count, 256);
    chk("wr0", {14'd0, log_off[0], log_dat[0]}, {14'd0, 10'h000, 8'hAA});
    chk("wr1", {14'd0, log_off[1], log_dat[1]}, {14'd0, 10'h001, 8'h55});
    chk("buf020", {24'd0, obuf[8'h20]}, 32'h55);
    chk("buf021", {24'd0, obuf[8'h21]}, 32'h55);
    chk("buf002", {24'd0, obuf[8'h02]}, 32'h72);
    chk("buf003", {24'd0, obuf[8'h03]}, 32'h8D);
    chk("buf040_zero", {24'd0, obuf[8'h40]}, 32'h00);
`ifdef RAM_READ_CHECKSUM_EN
    chk("dir_csum", {24'd0, BlockChecksum}, 32'hDF);
`else
    chk("dir_csum", {24'd0, BlockChecksum}, 32'h00);
`endif
    chk("dir_ncs_end", {31'd0, Ram_Reading_nCS}, 32'd1);
    @(posedge sys_clock);
    #1;
    chk("done_pulse_end", {31'd0, BlockReadDone}, 32'd0);
    chk("idle_busy", {31'd0, Gbd_Reading_Ram}, 32'd0);
    $display("block directed: writes=%0d csum=%h", wr_count, BlockChecksum);
    repeat (3) @(posedge sys_clock);
    #1;

    // Loopback over all 16 rounds and the wrap back to round 0.
    pulse_new_run();
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) src[r][i] = 8'($urandom);
      tile_write(r);
    end
    for (int r = 0; r < 17; r++) begin
      ack_mode = (r < 3) ? 1 : 0;
      for (int i = 0; i < 256; i++) obuf[i] = ~src[r % 16][i];
      exp_sum = exp_csum(r % 16);
      run_block();
      nerr = 0;
      for (int i = 0; i < 256; i++) if (obuf[i] !== src[r % 16][i]) nerr++;
      chk("lb_mismatches", nerr, 0);
      chk("lb_writes", wr_count, 256);
      chk("lb_first_addr", first_addr, (r % 16) * 256);
      chk("lb_csum", {24'd0, BlockChecksum}, {24'd0, exp_sum});
      $display("block loopback r=%0d: writes=%0d errors=%0d first_addr=%h", r, wr_count, nerr, first_addr);
      repeat (3) @(posedge sys_clock);
      #1;
    end
    ack_mode = 0;

    // Abort at write #100, then the next block must restart at round 0.
    pulse_new_run();
    run_block_abort();
    for (int i = 0; i < 256; i++) obuf[i] = ~src[0][i];
    run_block();
    nerr = 0;
    for (int i = 0; i < 256; i++) if (obuf[i] !== src[0][i]) nerr++;
    chk("post_abort_addr", first_addr, 0);
    chk("post_abort_data", nerr, 0);
    chk("post_abort_writes", wr_count, 256);
    $display("block after abort: writes=%0d errors=%0d first_addr=%h", wr_count, nerr, first_addr);
    repeat (3) @(posedge sys_clock);
    #1;

    // Checksum patterns on round 0.
    for (int i = 0; i < 256; i++) sram[i] = 8'h01;
    pulse_new_run();
    run_block();
    chk("csum_all01", {24'd0, BlockChecksum}, 32'h00);
    $display("block csum all01: csum=%h", BlockChecksum);
    repeat (3) @(posedge sys_clock);
    #1;
    for (int i = 0; i < 256; i++) sram[i] = 8'h00;
    sram[0] = 8'h03;
    pulse_new_run();
    run_block();
`ifdef RAM_READ_CHECKSUM_EN
    chk("csum_single03", {24'd0, BlockChecksum}, 32'h03);
`else
    chk("csum_single03", {24'd0, BlockChecksum}, 32'h00);
`endif
    $display("block csum single03: csum=%h", BlockChecksum);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic run_block_abort();
    logic reached;
    wr_count = 0;
    reached = 1'b0;
    BlockReadRequest = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge sys_clock);
      #2;
      if (wr_count >= 100) begin
        reached = 1'b1;
        break;
      end
    end
    chk("abort_reached", {31'd0, reached}, 32'd1);
    NewRunReset = 1'b1;
    @(posedge sys_clock);
    #1;
    chk("abort_ncs", {31'd0, Ram_Reading_nCS}, 32'd1);
    chk("abort_noe", {31'd0, Ram_Reading_nOE}, 32'd1);
    chk("abort_req", {31'd0, RequestWriteBuffer}, 32'd0);
    chk("abort_busy", {31'd0, Gbd_Reading_Ram}, 32'd0);
    NewRunReset = 1'b0;
    BlockReadRequest = 1'b0;
    $display("block aborted: writes=%0d", wr_count);
    repeat (4) @(posedge sys_clock);
    #1;
  endtask

endmodule
